sram_resp_agent: RTL and testbench

Memory-side responder for the CPU's SRAM-style request port (`en`/`we`/`addr`/`wdata` out, `rdata` in). It adds an address-accept/data-return handshake (`req_ready`/`resp_valid`) in place of the constant-1 `inst_ready`/`data_valid` ties. The block owns a word-addressed backing array, applies byte-enabled writes, and returns read data after a configurable delay. It sits below `mycpu_top`, one instance per port (inst, data), and lets the IF and MEM stalls be exercised under non-zero memory latency.

---
 rtl/sram_resp_pkg.sv | 22 ++
 rtl/sram_resp_agent_delay_lfsr.sv | 23 ++
 rtl/sram_resp_agent.sv | 110 +++++++++++
 tb/tb_sram_resp_agent.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/sram_resp_pkg.sv
// Shared types and constants for sram_resp_agent: FSM encoding, LFSR seed/taps and delay limit.
package sram_resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 map onto bits 15,13,12,10 of the shift register.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam int          MAX_DELAY = 15;

  function automatic logic [3:0] sat_delay(input int base, input logic [2:0] extra);
    int sum;
    sum = base + int'(extra);
    return (sum > MAX_DELAY) ? 4'(MAX_DELAY) : 4'(sum);
  endfunction

endpackage

// File: rtl/sram_resp_agent_delay_lfsr.sv
// 16-bit Fibonacci LFSR supplying the random part of the per-request delay; advances on step.
module delay_lfsr
  import sram_resp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  output logic [15:0] out
);

  logic feedback;

  assign feedback = ^(out & LFSR_TAPS);

  always_ff @(posedge clk) begin
    if (rst) begin
      out <= LFSR_SEED;
    end else if (step) begin
      out <= {out[14:0], feedback};
    end
  end

endmodule

// File: rtl/sram_resp_agent.sv
// SRAM-style memory responder with req/resp handshake, byte-enabled writes and a configurable delay.
// Define SRAM_RESP_RANDOM_DELAY_EN to add an LFSR-driven random component to the delay.
module sram_resp_agent
  import sram_resp_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int FIXED_DELAY = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_en,
  input  logic [3:0]  req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  input  logic        resp_ready
);

  localparam int DEPTH = 2 ** ADDR_W;

  state_t             state;
  state_t             state_nx;
  logic [3:0]         cnt;
  logic [3:0]         we_q;
  logic [ADDR_W-1:0]  idx_q;
  logic [31:0]        wdata_q;
  logic               accept;
  logic [3:0]         delay;
  logic [31:0]        mem [DEPTH];

  assign req_ready = (state == ST_IDLE);
  assign accept    = req_en && req_ready;

`ifdef SRAM_RESP_RANDOM_DELAY_EN
  logic [15:0] lfsr;

  delay_lfsr u_delay_lfsr (
    .clk  (clk),
    .rst  (rst),
    .step (accept),
    .out  (lfsr)
  );

  assign delay = sat_delay(FIXED_DELAY, lfsr[2:0]);

  logic unused_bits;
  assign unused_bits = ^{req_addr[31:ADDR_W+2], req_addr[1:0], lfsr[15:3]};
`else
  assign delay = 4'(FIXED_DELAY);

  logic unused_bits;
  assign unused_bits = ^{req_addr[31:ADDR_W+2], req_addr[1:0]};
`endif

  // NOTE: every combinational output gets a default before the case, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (accept) state_nx = (delay == 4'd0) ? ST_ACCESS : ST_WAIT;
      ST_WAIT:   if (cnt == 4'd0) state_nx = ST_ACCESS;
      ST_ACCESS: state_nx = ST_RESP;
      ST_RESP:   if (resp_ready) state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= 4'd0;
      we_q       <= 4'd0;
      idx_q      <= '0;
      wdata_q    <= 32'd0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
    end else begin
      state <= state_nx;

      if (accept) begin
        we_q    <= req_we;
        idx_q   <= req_addr[ADDR_W+1:2];
        wdata_q <= req_wdata;
        cnt     <= (delay == 4'd0) ? 4'd0 : delay - 4'd1;
      end else if (state == ST_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end

      // Read data lands in resp_rdata on the ACCESS->RESP edge; writes answer with zero.
      if (state == ST_ACCESS) begin
        resp_valid <= 1'b1;
        resp_rdata <= (we_q == 4'd0) ? mem[idx_q] : 32'd0;
      end else if (state == ST_RESP && resp_ready) begin
        resp_valid <= 1'b0;
      end
    end
  end

  // NOTE: the array is deliberately left out of reset so it maps onto block RAM and keeps its contents across rst.
  always_ff @(posedge clk) begin
    if (state == ST_ACCESS) begin
      for (int i = 0; i < 4; i++) begin
        if (we_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_sram_resp_agent.sv
// Randomized self-checking bench for sram_resp_agent: three instances (delay 0, 3, 4) against a queue-free reference model.
module tb_sram_resp_agent;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_en     [3];
  logic [3:0]  req_we     [3];
  logic [31:0] req_addr   [3];
  logic [31:0] req_wdata  [3];
  logic        req_ready  [3];
  logic        resp_valid [3];
  logic [31:0] resp_rdata [3];
  logic        resp_ready [3];

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] model_mem [3][4096];
  int          lfsr_m    [3];

  function automatic int fixed_of(input int k);
    return (k == 0) ? 0 : (k == 1) ? 3 : 4;
  endfunction

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sram_resp_agent #(.ADDR_W(12), .FIXED_DELAY(fixed_of(g))) u_dut (
      .clk        (clk),
      .rst        (rst),
      .req_en     (req_en[g]),
      .req_we     (req_we[g]),
      .req_addr   (req_addr[g]),
      .req_wdata  (req_wdata[g]),
      .req_ready  (req_ready[g]),
      .resp_valid (resp_valid[g]),
      .resp_rdata (resp_rdata[g]),
      .resp_ready (resp_ready[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Delay the reference picks for the next accept on instance k; advances its LFSR copy.
  function automatic int model_delay(input int k);
    int d;
    d = fixed_of(k);
`ifdef SRAM_RESP_RANDOM_DELAY_EN
    begin
      int fb;
      d = d + (lfsr_m[k] % 8);
      if (d > 15) d = 15;
      fb = ((lfsr_m[k] >> 15) ^ (lfsr_m[k] >> 13) ^ (lfsr_m[k] >> 12) ^ (lfsr_m[k] >> 10)) & 1;
      lfsr_m[k] = ((lfsr_m[k] * 2) + fb) % 65536;
    end
`endif
    return d;
  endfunction

  task automatic reset_model();
    for (int k = 0; k < 3; k++) lfsr_m[k] = 32'hACE1;
  endtask

  task automatic check_idle_outputs(input string tag, input int k);
    check({tag, "_req_ready"}, 32'(req_ready[k]), 32'd1);
    check({tag, "_resp_valid"}, 32'(resp_valid[k]), 32'd0);
    check({tag, "_resp_rdata"}, resp_rdata[k], 32'd0);
  endtask

  // One complete transaction; called at #1 after an edge with the instance in IDLE.
  task automatic do_txn(input int k, input logic [3:0] we, input logic [31:0] addr,
                        input logic [31:0] wdata, input int hold);
    int          d;
    int          lat;
    int          idx;
    bit          seen;
    logic [31:0] exp;
    logic [31:0] held;

    idx = int'(addr[13:2]);
    check("accept_ready", 32'(req_ready[k]), 32'd1);
    d = model_delay(k);
    if (we == 4'd0) begin
      exp = model_mem[k][idx];
    end else begin
      exp = 32'd0;
      for (int i = 0; i < 4; i++)
        if (we[i]) model_mem[k][idx][8*i +: 8] = wdata[8*i +: 8];
    end

    req_en[k]     = 1'b1;
    req_we[k]     = we;
    req_addr[k]   = addr;
    req_wdata[k]  = wdata;
    resp_ready[k] = (hold == 0);
    @(posedge clk); #1;
    // Scramble the request pins: the accepted request must already be latched.
    req_en[k]    = 1'b0;
    req_we[k]    = 4'($urandom);
    req_addr[k]  = $urandom;
    req_wdata[k] = $urandom;

    lat  = 1;
    seen = 1'b0;
    while (!seen && lat <= 40) begin
      if (resp_valid[k]) begin
        seen = 1'b1;
      end else begin
        check("busy_ready", 32'(req_ready[k]), 32'd0);
        @(posedge clk); #1;
        lat++;
      end
    end
    if (!seen) begin
      check("resp_timeout", 32'd0, 32'd1);
      return;
    end
    check("latency", 32'(lat), 32'(2 + d));
`ifdef SRAM_RESP_RANDOM_DELAY_EN
    if (k == 0) check("latency_range", 32'(lat >= 2 && lat <= 9), 32'd1);
`endif
    check("rdata", resp_rdata[k], exp);
    check("resp_ready_low", 32'(req_ready[k]), 32'd0);

    if (hold > 0) begin
      held = resp_rdata[k];
      // A competing read during the stall must not be accepted.
      req_en[k]   = 1'b1;
      req_we[k]   = 4'd0;
      req_addr[k] = addr;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        check("stall_valid", 32'(resp_valid[k]), 32'd1);
        check("stall_rdata", resp_rdata[k], held);
        check("stall_ready", 32'(req_ready[k]), 32'd0);
      end
      resp_ready[k] = 1'b1;
    end
    @(posedge clk); #1;
    check("done_valid", 32'(resp_valid[k]), 32'd0);
    check("done_ready", 32'(req_ready[k]), 32'd1);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      req_en[k]     = 1'b0;
      req_we[k]     = 4'd0;
      req_addr[k]   = 32'd0;
      req_wdata[k]  = 32'd0;
      resp_ready[k] = 1'b1;
    end

    // Reset for two cycles, then inspect the first cycle after release.
    rst = 1'b1;
    reset_model();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) check_idle_outputs("reset", k);

    // Write then read, byte merge, low address bits ignored.
    do_txn(0, 4'hF, 32'h0000_001C, 32'h1234_5678, 0);
    do_txn(0, 4'h0, 32'h0000_001C, 32'h0, 0);
    do_txn(0, 4'b0010, 32'h0000_001C, 32'h0000_AB00, 0);
    do_txn(0, 4'h0, 32'h0000_001C, 32'h0, 0);
    do_txn(0, 4'h0, 32'h0000_001D, 32'h0, 0);
    check("merge_literal", model_mem[0][7], 32'h1234_AB78);

    // Backpressure on the delay-3 instance; the competing read is taken right after release.
    do_txn(1, 4'hF, 32'h0000_0080, 32'hA5A5_0F0F, 0);
    do_txn(1, 4'h0, 32'h0000_0080, 32'h0, 5);
    do_txn(1, 4'h0, 32'h0000_0080, 32'h0, 0);

    // Reset while the delay-4 instance sits in WAIT: the interrupted write must be lost.
    do_txn(2, 4'hF, 32'h0000_0040, 32'hCAFE_F00D, 0);
    req_en[2]    = 1'b1;
    req_we[2]    = 4'hF;
    req_addr[2]  = 32'h0000_0040;
    req_wdata[2] = 32'hDEAD_BEEF;
    void'(model_delay(2));
    @(posedge clk); #1;
    req_en[2] = 1'b0;
    check("midwait_ready", 32'(req_ready[2]), 32'd0);
    @(posedge clk); #1;
    check("midwait_valid", 32'(resp_valid[2]), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    reset_model();
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) check_idle_outputs("midwait_reset", k);
    do_txn(2, 4'h0, 32'h0000_0040, 32'h0, 0);

    // Randomized traffic on the zero-delay instance over a fully initialised window.
    for (int w = 0; w < 16; w++)
      do_txn(0, 4'hF, 32'(w * 4), $urandom, 0);
    for (int n = 0; n < 1000; n++) begin
      logic [31:0] a;
      logic [3:0]  we;
      a  = ($urandom & 32'hFFFF_C000) | 32'($urandom_range(0, 15) * 4) | ($urandom & 32'd3);
      we = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
      do_txn(0, we, a, $urandom, ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
